// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: state type, default divider widths and a small helper for the PLL controller.
// The ERROR state is only part of the type when PLL_CTRL_TIMEOUT_EN is defined.
package pll_ctrl_pkg;

   localparam int DEF_REF_DIV_WIDTH = 4;
   localparam int DEF_FB_DIV_WIDTH  = 8;

   typedef enum logic [2:0] {
      ST_BYPASS    = 3'd0,
      ST_SWITCH    = 3'd1,
      ST_APPLY     = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_WAIT_LOCK = 3'd4,
      ST_LOCKED    = 3'd5
`ifdef PLL_CTRL_TIMEOUT_EN
      , ST_ERROR   = 3'd6
`endif
   } pll_ctrl_state_e;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_ctrl_sync.sv
// pll_ctrl_sync: two-flop synchroniser for the asynchronous PLL lock indication.
// Both flops clear on the asynchronous active-high reset.
module pll_ctrl_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_ctrl.sv
// pll_ctrl: PLL reconfiguration sequencer -- clock-mux handover, divider update, settle and lock monitor.
// Defining PLL_CTRL_TIMEOUT_EN adds the WAIT_LOCK timeout counter, the ERROR state and a sticky error_o.
module pll_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int REF_DIV_WIDTH  = DEF_REF_DIV_WIDTH,
   parameter int FB_DIV_WIDTH   = DEF_FB_DIV_WIDTH,
   parameter int SWITCH_CYCLES  = 2,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                     clk_i,
   input  logic                     arst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [REF_DIV_WIDTH-1:0] req_ref_div_i,
   input  logic [FB_DIV_WIDTH-1:0]  req_fb_div_i,
   output logic [REF_DIV_WIDTH-1:0] ref_div_o,
   output logic [FB_DIV_WIDTH-1:0]  fb_div_o,
   input  logic                     pll_locked_i,
   output logic                     clk_sel_o,
   output logic                     busy_o,
   output logic                     error_o,
   output logic                     lock_lost_o
);

   // state     | meaning
   // BYPASS    | idle after reset, system clock from clk_i
   // SWITCH    | mux moved to clk_i, waiting for it to settle
   // APPLY     | new dividers driven to the PLL
   // SETTLE    | dividers held before lock is trusted
   // WAIT_LOCK | waiting for synchronised lock
   // LOCKED    | PLL clock selected, lock monitored
   // ERROR     | lock timeout (timeout build only)

`ifdef PLL_CTRL_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif
   localparam int TMO_MAX = TIMEOUT_EN ? TIMEOUT_CYCLES : 0;
   localparam int CNT_MAX = max_of(max_of(SWITCH_CYCLES, SETTLE_CYCLES), TMO_MAX);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SWITCH_LOAD = CNT_W'(SWITCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef PLL_CTRL_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   pll_ctrl_state_e            r_state;
   pll_ctrl_state_e            w_state_nxt;
   logic [CNT_W-1:0]           r_cnt;
   logic [CNT_W-1:0]           w_cnt_nxt;
   logic [REF_DIV_WIDTH-1:0]   r_hold_ref;
   logic [FB_DIV_WIDTH-1:0]    r_hold_fb;
   logic [REF_DIV_WIDTH-1:0]   r_ref_div;
   logic [FB_DIV_WIDTH-1:0]    r_fb_div;
   logic                       r_clk_sel;
   logic                       w_clk_sel_nxt;
   logic                       r_lock_lost;
   logic                       w_lock_lost_nxt;
   logic                       w_load_div;
   logic                       w_ready;
   logic                       w_hs;
   logic                       w_lock_s;
`ifdef PLL_CTRL_TIMEOUT_EN
   logic                       r_error;
   logic                       w_error_nxt;
`endif

   pll_ctrl_sync u_sync (
      .i_clk (clk_i),
      .i_rst (arst_i),
      .i_d   (pll_locked_i),
      .o_q   (w_lock_s)
   );

`ifdef PLL_CTRL_TIMEOUT_EN
   assign w_ready = (r_state == ST_BYPASS) || (r_state == ST_LOCKED) || (r_state == ST_ERROR);
`else
   assign w_ready = (r_state == ST_BYPASS) || (r_state == ST_LOCKED);
`endif
   assign w_hs = req_valid_i && w_ready;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state <= ST_BYPASS;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_clk_sel_nxt   = r_clk_sel;
      w_lock_lost_nxt = 1'b0;
      w_load_div      = 1'b0;
`ifdef PLL_CTRL_TIMEOUT_EN
      w_error_nxt     = r_error;
`endif
      unique case (r_state)
         ST_BYPASS: begin
            w_clk_sel_nxt = 1'b0;
         end
         ST_SWITCH: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_APPLY;
               w_load_div  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_APPLY: begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = SETTLE_LOAD;
         end
         ST_SETTLE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_WAIT_LOCK;
`ifdef PLL_CTRL_TIMEOUT_EN
               w_cnt_nxt   = TMO_LOAD;
`endif
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (w_lock_s) begin
               w_state_nxt = ST_LOCKED;
`ifdef PLL_CTRL_TIMEOUT_EN
            end else if (r_cnt == '0) begin
               w_state_nxt   = ST_ERROR;
               w_error_nxt   = 1'b1;
               w_clk_sel_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
`endif
            end
         end
         ST_LOCKED: begin
            if (w_lock_s) begin
               w_clk_sel_nxt = 1'b1;
            end else begin
               w_state_nxt     = ST_WAIT_LOCK;
               w_clk_sel_nxt   = 1'b0;
               w_lock_lost_nxt = 1'b1;
`ifdef PLL_CTRL_TIMEOUT_EN
               w_cnt_nxt       = TMO_LOAD;
`endif
            end
         end
`ifdef PLL_CTRL_TIMEOUT_EN
         ST_ERROR: begin
            w_clk_sel_nxt = 1'b0;
         end
`endif
         default: begin
            w_state_nxt   = ST_BYPASS;
            w_clk_sel_nxt = 1'b0;
         end
      endcase
      // A new request beats a simultaneous lock loss: no pulse, straight to SWITCH.
      if (w_hs) begin
         w_state_nxt     = ST_SWITCH;
         w_cnt_nxt       = SWITCH_LOAD;
         w_clk_sel_nxt   = 1'b0;
         w_lock_lost_nxt = 1'b0;
`ifdef PLL_CTRL_TIMEOUT_EN
         w_error_nxt     = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_cnt       <= '0;
         r_hold_ref  <= '0;
         r_hold_fb   <= '0;
         r_ref_div   <= '0;
         r_fb_div    <= '0;
         r_clk_sel   <= 1'b0;
         r_lock_lost <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_clk_sel   <= w_clk_sel_nxt;
         r_lock_lost <= w_lock_lost_nxt;
         if (w_hs) begin
            r_hold_ref <= req_ref_div_i;
            r_hold_fb  <= req_fb_div_i;
         end
         if (w_load_div) begin
            r_ref_div <= r_hold_ref;
            r_fb_div  <= r_hold_fb;
         end
      end
   end

`ifdef PLL_CTRL_TIMEOUT_EN
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_error <= 1'b0;
      end else begin
         r_error <= w_error_nxt;
      end
   end
   assign error_o = r_error;
`else
   assign error_o = 1'b0;
`endif

   assign req_ready_o = w_ready;
   assign busy_o      = (r_state == ST_SWITCH) || (r_state == ST_APPLY) ||
                        (r_state == ST_SETTLE) || (r_state == ST_WAIT_LOCK);
   assign ref_div_o   = r_ref_div;
   assign fb_div_o    = r_fb_div;
   assign clk_sel_o   = r_clk_sel;
   assign lock_lost_o = r_lock_lost;

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: directed self-checking bench for pll_ctrl (timeout path exercised when PLL_CTRL_TIMEOUT_EN is defined).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pll_ctrl;

   localparam int RW = 4;
   localparam int FW = 8;
   localparam int SW = 2;
   localparam int ST = 16;
   localparam int TO = 4096;

   logic          clk_i = 1'b0;
   logic          arst_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [RW-1:0] req_ref_div_i;
   logic [FW-1:0] req_fb_div_i;
   logic [RW-1:0] ref_div_o;
   logic [FW-1:0] fb_div_o;
   logic          pll_locked_i;
   logic          clk_sel_o;
   logic          busy_o;
   logic          error_o;
   logic          lock_lost_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   pll_ctrl #(
      .REF_DIV_WIDTH  (RW),
      .FB_DIV_WIDTH   (FW),
      .SWITCH_CYCLES  (SW),
      .SETTLE_CYCLES  (ST),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i         (clk_i),
      .arst_i        (arst_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_ref_div_i (req_ref_div_i),
      .req_fb_div_i  (req_fb_div_i),
      .ref_div_o     (ref_div_o),
      .fb_div_o      (fb_div_o),
      .pll_locked_i  (pll_locked_i),
      .clk_sel_o     (clk_sel_o),
      .busy_o        (busy_o),
      .error_o       (error_o),
      .lock_lost_o   (lock_lost_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic check_reset_vals(input string p);
      check_val({p, "_clk_sel"},   32'(clk_sel_o),   32'd0);
      check_val({p, "_ref_div"},   32'(ref_div_o),   32'd0);
      check_val({p, "_fb_div"},    32'(fb_div_o),    32'd0);
      check_val({p, "_busy"},      32'(busy_o),      32'd0);
      check_val({p, "_error"},     32'(error_o),     32'd0);
      check_val({p, "_lock_lost"}, 32'(lock_lost_o), 32'd0);
      check_val({p, "_ready"},     32'(req_ready_o), 32'd1);
   endtask

   task automatic send_req(input logic [RW-1:0] r, input logic [FW-1:0] f);
      req_ref_div_i = r;
      req_fb_div_i  = f;
      req_valid_i   = 1'b1;
      tick();
      req_valid_i   = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int n = 0;
      while (busy_o && n < max_cyc) begin
         tick();
         n++;
      end
      check_val(tag, 32'(busy_o), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      arst_i        = 1'b1;
      req_valid_i   = 1'b0;
      req_ref_div_i = '0;
      req_fb_div_i  = '0;
      pll_locked_i  = 1'b0;
      tick(3);
      check_reset_vals("in_rst");
      arst_i = 1'b0;
      tick(2);
      check_reset_vals("post_rst");

      // First configuration 2/20, lock arrives ~100 cycles after the handshake
      send_req(4'd2, 8'd20);
      check_val("sw1_busy",    32'(busy_o),      32'd1);
      check_val("sw1_ready",   32'(req_ready_o), 32'd0);
      check_val("sw1_clk_sel", 32'(clk_sel_o),   32'd0);
      check_val("sw1_ref",     32'(ref_div_o),   32'd0);
      tick();
      check_val("sw2_ref",     32'(ref_div_o),   32'd0);
      check_val("sw2_fb",      32'(fb_div_o),    32'd0);
      tick();
      check_val("apply_ref",   32'(ref_div_o),   32'd2);
      check_val("apply_fb",    32'(fb_div_o),    32'd20);
      tick(97);
      check_val("wl_busy",     32'(busy_o),      32'd1);
      check_val("wl_clk_sel",  32'(clk_sel_o),   32'd0);
      pll_locked_i = 1'b1;
      tick(3);
      check_val("lk_entry_busy",  32'(busy_o),      32'd0);
      check_val("lk_entry_ready", 32'(req_ready_o), 32'd1);
      check_val("lk_entry_csel",  32'(clk_sel_o),   32'd0);
      tick();
      check_val("lk_csel_on",     32'(clk_sel_o),   32'd1);

      // Lock loss in LOCKED
      pll_locked_i = 1'b0;
      tick(2);
      check_val("pre_loss_csel",  32'(clk_sel_o),   32'd1);
      check_val("pre_loss_pulse", 32'(lock_lost_o), 32'd0);
      tick();
      check_val("loss_pulse",     32'(lock_lost_o), 32'd1);
      check_val("loss_csel",      32'(clk_sel_o),   32'd0);
      check_val("loss_busy",      32'(busy_o),      32'd1);
      check_val("loss_ready",     32'(req_ready_o), 32'd0);
      check_val("loss_ref",       32'(ref_div_o),   32'd2);
      check_val("loss_fb",        32'(fb_div_o),    32'd20);
      tick();
      check_val("loss_pulse_end", 32'(lock_lost_o), 32'd0);
      check_val("loss_still_wl",  32'(busy_o),      32'd1);
      pll_locked_i = 1'b1;
      tick(4);
      check_val("relock_csel",    32'(clk_sel_o),   32'd1);
      check_val("relock_busy",    32'(busy_o),      32'd0);

      // Request 5/33, then a second request held through SETTLE
      send_req(4'd5, 8'd33);
      check_val("r2_csel",        32'(clk_sel_o),   32'd0);
      check_val("r2_busy",        32'(busy_o),      32'd1);
      tick(2);
      check_val("r2_apply_ref",   32'(ref_div_o),   32'd5);
      check_val("r2_apply_fb",    32'(fb_div_o),    32'd33);
      req_ref_div_i = 4'd7;
      req_fb_div_i  = 8'd99;
      req_valid_i   = 1'b1;
      tick();
      check_val("settle_ready",   32'(req_ready_o), 32'd0);
      tick(15);
      check_val("settle_end_rdy", 32'(req_ready_o), 32'd0);
      check_val("settle_end_ref", 32'(ref_div_o),   32'd5);
      check_val("settle_end_fb",  32'(fb_div_o),    32'd33);
      tick();
      check_val("wl_no_capture",  32'(ref_div_o),   32'd5);
      check_val("wl_busy2",       32'(busy_o),      32'd1);
      tick();
      check_val("lk_ready_held",  32'(req_ready_o), 32'd1);
      tick();
      req_valid_i = 1'b0;
      check_val("held_accepted",  32'(busy_o),      32'd1);
      tick(2);
      check_val("held_apply_ref", 32'(ref_div_o),   32'd7);
      check_val("held_apply_fb",  32'(fb_div_o),    32'd99);
      wait_idle(40, "held_relock_timeout");
      tick();
      check_val("held_csel_on",   32'(clk_sel_o),   32'd1);

      // Same dividers again still run the whole sequence
      send_req(4'd7, 8'd99);
      n = 0;
      while (busy_o && n < 200) begin
         n++;
         tick();
      end
      check_val("same_req_busy_len", 32'(n),        32'(SW + 1 + ST + 1));
      check_val("same_req_ref",      32'(ref_div_o), 32'd7);

      // Handshake on the same cycle lock_s falls
      tick();
      check_val("race_pre_csel",  32'(clk_sel_o),   32'd1);
      pll_locked_i = 1'b0;
      tick(2);
      send_req(4'd3, 8'd10);
      check_val("race_no_pulse0", 32'(lock_lost_o), 32'd0);
      check_val("race_busy",      32'(busy_o),      32'd1);
      check_val("race_csel",      32'(clk_sel_o),   32'd0);
      tick();
      check_val("race_no_pulse1", 32'(lock_lost_o), 32'd0);
      tick();
      check_val("race_apply_ref", 32'(ref_div_o),   32'd3);
      check_val("race_apply_fb",  32'(fb_div_o),    32'd10);

      // Asynchronous reset while in WAIT_LOCK
      tick(30);
      check_val("wl_before_rst",  32'(busy_o),      32'd1);
      #2;
      arst_i = 1'b1;
      #1;
      check_reset_vals("async_rst");
      tick(2);
      arst_i = 1'b0;
      tick(3);
      check_reset_vals("rst_abandon");

`ifdef PLL_CTRL_TIMEOUT_EN
      send_req(4'd1, 8'd4);
      tick(SW + 1 + ST);
      tick(TO - 1);
      check_val("tmo_pre_err",    32'(error_o),     32'd0);
      check_val("tmo_pre_busy",   32'(busy_o),      32'd1);
      tick();
      check_val("tmo_err",        32'(error_o),     32'd1);
      check_val("tmo_busy",       32'(busy_o),      32'd0);
      check_val("tmo_ready",      32'(req_ready_o), 32'd1);
      check_val("tmo_csel",       32'(clk_sel_o),   32'd0);
      send_req(4'd2, 8'd8);
      check_val("tmo_err_clr",    32'(error_o),     32'd0);
      check_val("tmo_new_busy",   32'(busy_o),      32'd1);
`else
      send_req(4'd1, 8'd4);
      tick(SW + 1 + ST + TO + 100);
      check_val("no_tmo_err",     32'(error_o),     32'd0);
      check_val("no_tmo_busy",    32'(busy_o),      32'd1);
      check_val("no_tmo_ready",   32'(req_ready_o), 32'd0);
      check_val("no_tmo_csel",    32'(clk_sel_o),   32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
